// File: rtl/mini_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_pkg
//  Brief    : Shared types and constants for the mini ALU sequential divider.
//  Revision : 1.0 - initial release
// ============================================================================
package mini_alu_pkg;

  // Default operand/result width of the ALU datapath.
  localparam int DEF_WIDTH = 16;

  // Width of the iteration counter; holds values 0 .. DEF_WIDTH-1.
  localparam int CNT_WIDTH = $clog2(DEF_WIDTH);

  // Quotient reported when the divisor is zero.
  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/mini_alu_16bit_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_16bit_div_if
//  Brief    : Operand/result bundle and start/busy/valid handshake of the
//             divider. The master drives operands, the slave returns results.
//  Revision : 1.0 - initial release
// ============================================================================
interface mini_alu_16bit_div_if
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, data0, data1,
    input  busy, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, data0, data1,
    output busy, valid, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mini_alu_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_div_step
//  Brief    : One combinational restoring-division step: shift the next
//             dividend bit into the partial remainder and conditionally
//             subtract the divisor.
//  Revision : 1.0 - initial release
// ============================================================================
module mini_alu_div_step
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The shifted remainder needs one extra bit so the compare cannot overflow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {rem_i, msb_i};
  // Only used when w_shift >= divisor, where the true difference is below
  // the divisor and therefore fits in WIDTH bits.
  assign w_diff  = w_shift[WIDTH-1:0] - divisor_i;
  assign qbit_o  = (w_shift >= {1'b0, divisor_i});
  assign rem_o   = qbit_o ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mini_alu_16bit_div.sv
`default_nettype none
// ============================================================================
//  Module   : mini_alu_16bit_div
//  Brief    : Sequential unsigned restoring divider. One quotient bit per
//             clock, results after WIDTH steps, divide-by-zero short-cut.
//  Revision : 1.0 - initial release
// ============================================================================
module mini_alu_16bit_div
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  mini_alu_16bit_div_if.slave        div_if
);

  localparam int                CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST_CNT = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;    // dividend in, quotient bits shift in
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] remd_q,  remd_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;
  logic [WIDTH-1:0] w_dvd_shift;

  mini_alu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (w_step_rem),
    .qbit_o    (w_step_qbit)
  );

  assign w_dvd_shift = {dvd_q[WIDTH-2:0], w_step_qbit};

  // Register every piece of state; reset clears the FSM and all datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath updates; results only change on a result load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (div_if.start) begin
          if (div_if.data1 == '0) begin
            // Zero divisor: skip iteration and report immediately.
            quot_d  = '1;
            remd_d  = div_if.data0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = div_if.data0;
            dvs_d   = div_if.data1;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = w_dvd_shift;
        rem_d = w_step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          quot_d  = w_dvd_shift;
          remd_d  = w_step_rem;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_if.busy        = (state_q == RUN);
  assign div_if.valid       = (state_q == DONE);
  assign div_if.quotient    = quot_q;
  assign div_if.remainder   = remd_q;
  assign div_if.div_by_zero = dbz_q;

endmodule
`default_nettype wire
